// File: rtl/stage3_execute_if.sv
// Execute-stage bus: ID/EX pipeline registers in, EX/MEM pipeline registers out, plus flush/stall.
// Latency: none (wiring only); the execute stage registers EX/MEM one edge after ID/EX presents an op.
// Backpressure: stall from the execute stage holds PC, IF/ID and ID/EX while a MUL iterates.
//
// Ports (master = decode/MEM side, slave = execute stage):
//   flush                        kill the op in EX, abort MUL
//   idexPc/Data1/Data2/Rd        instruction PC, rs1/rs2 values, destination reg
//   idexFunc7/Func3              inst[31:25], inst[14:12]
//   idexExpandInst               sign-extended immediate, low XLEN bits used
//   idexExCtrl/MemCtrl/WbCtrl    {aluOp, aluSrc}, {branch, memWrite, memRead}, {memToReg, regWrite}
//   stall                        hold upstream stages
//   exmem*                       EX/MEM registers (ctrl fields zero for a bubble)
interface stage3_execute_if #(
  parameter int XLEN = 32
);
  logic            flush;
  logic            stall;
  logic [XLEN-1:0] idexPc;
  logic [XLEN-1:0] idexData1;
  logic [XLEN-1:0] idexData2;
  logic [4:0]      idexRd;
  logic [6:0]      idexFunc7;
  logic [2:0]      idexFunc3;
  logic [63:0]     idexExpandInst;
  logic [2:0]      idexExCtrl;
  logic [2:0]      idexMemCtrl;
  logic [1:0]      idexWbCtrl;
  logic [XLEN-1:0] exmemAluResult;
  logic [XLEN-1:0] exmemData2;
  logic [XLEN-1:0] exmemBranchTarget;
  logic            exmemBranchTaken;
  logic [4:0]      exmemRd;
  logic [2:0]      exmemMemCtrl;
  logic [1:0]      exmemWbCtrl;

  modport master (
    output flush, idexPc, idexData1, idexData2, idexRd, idexFunc7, idexFunc3,
           idexExpandInst, idexExCtrl, idexMemCtrl, idexWbCtrl,
    input  stall, exmemAluResult, exmemData2, exmemBranchTarget, exmemBranchTaken,
           exmemRd, exmemMemCtrl, exmemWbCtrl
  );

  modport slave (
    input  flush, idexPc, idexData1, idexData2, idexRd, idexFunc7, idexFunc3,
           idexExpandInst, idexExCtrl, idexMemCtrl, idexWbCtrl,
    output stall, exmemAluResult, exmemData2, exmemBranchTarget, exmemBranchTaken,
           exmemRd, exmemMemCtrl, exmemWbCtrl
  );
endinterface

// File: rtl/stage3_execute.sv
// Execute stage: single-cycle ALU, branch compare/target, iterative shift-add MUL (low word).
// Latency: 1 edge for ALU/branch ops; MUL result lands MUL_ITERS+2 edges after it is presented.
// Backpressure: stall is high from MUL entry until the final iteration; EX/MEM receives bubbles meanwhile.
//
// Ports: clk, rst_n (async, active low), ex (stage3_execute_if.slave: ID/EX in, EX/MEM out, flush, stall).
module stage3_execute #(
  parameter int XLEN      = 32,
  parameter int MUL_ITERS = 32
) (
  input logic             clk,
  input logic             rst_n,
  stage3_execute_if.slave ex
);
  localparam int SH_W  = $clog2(XLEN);
  localparam int CNT_W = $clog2(MUL_ITERS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_ITERS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [XLEN-1:0] imm, op_a, op_b, rs2;
  logic            alu_src;
  logic [1:0]      alu_op;
  logic [SH_W-1:0] shamt;
  logic            sub_sel, sra_sel, is_mul;
  logic [XLEN-1:0] alu_res, sra_res, br_target;
  logic            br_cond, br_taken;
  logic            unused_imm_hi;

  // FSM outputs
  logic stall_fsm, bubble, write_op, sel_mul, mul_start, mul_step;

  // Multiplier datapath
  logic [XLEN-1:0]  mul_a_q, mul_b_q, prod_q;
  logic [CNT_W-1:0] cnt_q;

  // EX/MEM registers
  logic [XLEN-1:0] res_q, data2_q, target_q;
  logic            taken_q;
  logic [4:0]      rd_q;
  logic [2:0]      mem_q;
  logic [1:0]      wb_q;

  assign imm           = ex.idexExpandInst[XLEN-1:0];
  assign unused_imm_hi = ^ex.idexExpandInst[63:XLEN];
  assign alu_src       = ex.idexExCtrl[0];
  assign alu_op        = ex.idexExCtrl[2:1];
  assign op_a          = ex.idexData1;
  assign rs2           = ex.idexData2;
  assign op_b          = alu_src ? imm : rs2;
  assign shamt         = op_b[SH_W-1:0];
  // For I-type ops func7[5] aliases imm[10], so only R-type may select SUB.
  assign sub_sel       = !alu_src && ex.idexFunc7[5];
  assign sra_sel       = ex.idexFunc7[5];
  assign is_mul        = (alu_op == 2'b10) && !alu_src && (ex.idexFunc7 == 7'b0000001);
  // Kept in its own signal so the shift stays signed (arithmetic).
  assign sra_res       = $signed(op_a) >>> shamt;
  assign br_target     = ex.idexPc + imm;
  assign br_taken      = ex.idexMemCtrl[2] & br_cond;

  always_comb begin
    alu_res = '0;
    case (alu_op)
      2'b00: alu_res = op_a + op_b;
      2'b01: alu_res = op_a - rs2;
      2'b11: alu_res = imm;
      default: begin
        case (ex.idexFunc3)
          3'b000:  alu_res = sub_sel ? (op_a - op_b) : (op_a + op_b);
          3'b001:  alu_res = op_a << shamt;
          3'b010:  alu_res = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
          3'b011:  alu_res = {{(XLEN-1){1'b0}}, (op_a < op_b)};
          3'b100:  alu_res = op_a ^ op_b;
          3'b101:  alu_res = sra_sel ? sra_res : (op_a >> shamt);
          3'b110:  alu_res = op_a | op_b;
          default: alu_res = op_a & op_b;
        endcase
      end
    endcase
  end

  always_comb begin
    br_cond = 1'b0;
    case (ex.idexFunc3)
      3'b000:  br_cond = (op_a == rs2);
      3'b001:  br_cond = (op_a != rs2);
      3'b100:  br_cond = ($signed(op_a) <  $signed(rs2));
      3'b101:  br_cond = ($signed(op_a) >= $signed(rs2));
      3'b110:  br_cond = (op_a <  rs2);
      3'b111:  br_cond = (op_a >= rs2);
      default: br_cond = 1'b0;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // FSM next state / outputs. flush wins over everything, including a new MUL.
  always_comb begin
    state_d   = state_q;
    stall_fsm = 1'b0;
    bubble    = 1'b0;
    write_op  = 1'b0;
    sel_mul   = 1'b0;
    mul_start = 1'b0;
    mul_step  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (ex.flush) begin
          bubble = 1'b1;
        end else if (is_mul) begin
          stall_fsm = 1'b1;
          bubble    = 1'b1;
          mul_start = 1'b1;
          state_d   = S_MUL;
        end else begin
          write_op = 1'b1;
        end
      end
      S_MUL: begin
        bubble = 1'b1;
        if (ex.flush) begin
          state_d = S_IDLE;
        end else begin
          stall_fsm = 1'b1;
          mul_step  = 1'b1;
          if (cnt_q == CNT_LAST) state_d = S_DONE;
        end
      end
      S_DONE: begin
        // The MUL is still held in ID/EX, so rd/ctrl come straight from there.
        if (ex.flush) begin
          bubble = 1'b1;
        end else begin
          write_op = 1'b1;
          sel_mul  = 1'b1;
        end
        state_d = S_IDLE;
      end
      default: begin
        bubble  = 1'b1;
        state_d = S_IDLE;
      end
    endcase
  end

  // Upstream must never see a hold while this stage sits in reset.
  assign ex.stall = stall_fsm & rst_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mul_a_q <= '0;
      mul_b_q <= '0;
      prod_q  <= '0;
      cnt_q   <= '0;
    end else if (mul_start) begin
      mul_a_q <= op_a;
      mul_b_q <= rs2;
      prod_q  <= '0;
      cnt_q   <= '0;
    end else if (mul_step) begin
      if (mul_b_q[0]) prod_q <= prod_q + mul_a_q;
      mul_a_q <= mul_a_q << 1;
      mul_b_q <= mul_b_q >> 1;
      cnt_q   <= cnt_q + 1'b1;
    end else if (ex.flush) begin
      cnt_q <= '0;
    end
  end

  // Bubbles only clear the control fields; data fields hold their last value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q    <= '0;
      data2_q  <= '0;
      target_q <= '0;
      taken_q  <= 1'b0;
      rd_q     <= '0;
      mem_q    <= '0;
      wb_q     <= '0;
    end else if (bubble) begin
      taken_q <= 1'b0;
      mem_q   <= '0;
      wb_q    <= '0;
    end else if (write_op) begin
      res_q    <= sel_mul ? prod_q : alu_res;
      data2_q  <= rs2;
      target_q <= br_target;
      taken_q  <= br_taken;
      rd_q     <= ex.idexRd;
      mem_q    <= ex.idexMemCtrl;
      wb_q     <= ex.idexWbCtrl;
    end
  end

  assign ex.exmemAluResult    = res_q;
  assign ex.exmemData2        = data2_q;
  assign ex.exmemBranchTarget = target_q;
  assign ex.exmemBranchTaken  = taken_q;
  assign ex.exmemRd           = rd_q;
  assign ex.exmemMemCtrl      = mem_q;
  assign ex.exmemWbCtrl       = wb_q;
endmodule
